// File: rtl/dump_sequencer.sv
// Sequences an oldest-first readout of one channel's circular capture RAM into uart_tx.
// Rejected requests answer with a single 0xEE byte flagged by nak.
module dump_sequencer #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_req,
  input  logic [2:0]      dump_ch,
  input  logic [LOG2-1:0] trig_pos,
  output logic [2:0]      ram_sel,
  output logic [LOG2-1:0] ram_addr,
  output logic            ram_rd_en,
  input  logic [7:0]      ram_rdata,
  output logic [7:0]      tx_data,
  output logic            trmt,
  input  logic            tx_done,
  output logic            busy,
  output logic            dump_done,
  output logic            nak
);

  localparam logic [LOG2:0]   EntriesW = (LOG2 + 1)'(ENTRIES);
  localparam logic [LOG2-1:0] LastIdx  = LOG2'(ENTRIES - 1);
  localparam logic [7:0]      NakByte  = 8'hEE;

  typedef enum logic [2:0] {StIdle, StRd, StWt, StLd, StTx, StNak} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [LOG2-1:0] addr_q, addr_d;
  logic [LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            rd_en_q, rd_en_d;
  logic            trmt_q, trmt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            nak_q, nak_d;
  logic            req_ok;

  assign req_ok = (dump_ch >= 3'd1) && (dump_ch <= 3'd5) && ({1'b0, trig_pos} < EntriesW);

  // Pulse outputs are computed for the state being entered so every output stays registered.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    rd_en_d   = 1'b0;
    trmt_d    = 1'b0;
    done_d    = 1'b0;
    nak_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (dump_req) begin
          if (req_ok) begin
            sel_d   = dump_ch;
            addr_d  = trig_pos;
            cnt_d   = '0;
            busy_d  = 1'b1;
            rd_en_d = 1'b1;
            state_d = StRd;
          end else begin
            tx_data_d = NakByte;
            trmt_d    = 1'b1;
            nak_d     = 1'b1;
            state_d   = StNak;
          end
        end
      end
      StRd: state_d = StWt;
      StWt: begin
        tx_data_d = ram_rdata;
        trmt_d    = 1'b1;
        state_d   = StLd;
      end
      StLd: state_d = StTx;
      StTx: begin
        if (tx_done) begin
          if (cnt_q == LastIdx) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            // Wrap at the last real entry, not at the address-space size.
            addr_d  = (addr_q == LastIdx) ? '0 : addr_q + 1'b1;
            rd_en_d = 1'b1;
            state_d = StRd;
          end
        end
      end
      StNak: begin
        if (tx_done) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      rd_en_q   <= 1'b0;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nak_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      rd_en_q   <= rd_en_d;
      trmt_q    <= trmt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nak_q     <= nak_d;
    end
  end

  assign ram_sel   = sel_q;
  assign ram_addr  = addr_q;
  assign ram_rd_en = rd_en_q;
  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign busy      = busy_q;
  assign dump_done = done_q;
  assign nak       = nak_q;

endmodule

// File: doc/dump_sequencer.md
Name: dump_sequencer

Overview:
- Controller that sequences readout of one channel's circular capture RAM to the host UART transmitter after a DUMP command.
- Sits between the command processor (issues dump_req, channel select and trigger position) and the capture RAMs/uart_tx in LA_dig.
- Reads ENTRIES samples oldest-first, starting at the trigger/write pointer and wrapping modulo ENTRIES. Each byte is handed to the transmitter with a trmt/tx_done handshake.

Parameters:
ENTRIES, 384, number of samples per channel RAM (12288 on DE-0); need not be a power of 2
LOG2, 9, address width; 2^LOG2 >= ENTRIES

Ports:
clk  input  1  system clock (100MHz domain)
rst_n  input  1  asynchronous active-low reset
dump_req  input  1  one-cycle pulse from command processor requesting a dump
dump_ch  input  3  channel to dump; 1..5 valid
trig_pos  input  LOG2  address of oldest sample (write pointer at capture end)
ram_sel  output  3  selects which channel RAM drives ram_rdata
ram_addr  output  LOG2  RAM read address
ram_rd_en  output  1  RAM read strobe; synchronous RAM, data valid the next cycle
ram_rdata  input  8  read data from the selected RAM
tx_data  output  8  byte to uart_tx
trmt  output  1  one-cycle start pulse to uart_tx
tx_done  input  1  one-cycle pulse from uart_tx when a byte completes
busy  output  1  high from the cycle after accepted dump_req until the cycle dump_done is pulsed
dump_done  output  1  one-cycle pulse when the final byte's tx_done is received
nak  output  1  one-cycle pulse, coincident with trmt, when a request is rejected

Behaviour:
- Reset: state IDLE. ram_sel=0, ram_addr=0, ram_rd_en=0, tx_data=8'h00, trmt=0, busy=0, dump_done=0, nak=0. Byte counter=0. All outputs are registered.
- States: IDLE, RD, WT, LD, TX, NAK.
- IDLE:
  - dump_req with dump_ch in 1..5 and trig_pos<ENTRIES: latch dump_ch into ram_sel and trig_pos into ram_addr, clear the counter, go to RD.
  - dump_req with any other dump_ch (0, 6, 7) or trig_pos>=ENTRIES: go to NAK.
- RD: ram_rd_en=1 for exactly this cycle, then go to WT.
- WT: ram_rdata is valid. Register tx_data<=ram_rdata and go to LD.
- LD: trmt=1 for exactly one cycle, then go to TX.
- TX: wait for tx_done; the wait is unbounded.
  - If counter==ENTRIES-1: pulse dump_done and go to IDLE.
  - Otherwise: counter++ and ram_addr<=(ram_addr==ENTRIES-1)?0:ram_addr+1, then go to RD.
- NAK: tx_data=8'hEE, trmt=1 and nak=1 for one cycle. Wait for tx_done, pulse dump_done, go to IDLE. ram_rd_en is never asserted on a NAK.
- Wrap-around: the address wraps at ENTRIES-1, not at 2^LOG2. Exactly ENTRIES bytes are sent per dump, covering addresses trig_pos..ENTRIES-1 then 0..trig_pos-1.
- Latency: dump_req cycle N gives ram_rd_en in cycle N+1 and the first trmt in cycle N+3. Each subsequent byte's ram_rd_en comes 1 cycle after the previous tx_done.
- tx_data is held stable from trmt until the next WT/NAK update.
- dump_req while not IDLE is ignored; no queuing.
- dump_ch and trig_pos changes after acceptance have no effect.
- tx_done outside TX/NAK-wait is ignored.
- tx_done in the same cycle as trmt cannot occur: uart_tx needs at least one bit time.
- Asynchronous reset mid-dump: return immediately to IDLE with reset values. No dump_done is issued.

Test Plan:
1. ENTRIES=384, trig_pos=0, dump_ch=1, RAM preloaded data=addr[7:0], tx_done 5 cycles after each trmt -> 384 trmt pulses with bytes 00..FF,00..7F; ram_addr sequence 0..383; one dump_done after the final tx_done; busy low afterwards.
2. trig_pos=380, dump_ch=3 -> ram_sel=3; addresses 380,381,382,383,0,1,...,379 (wrap at 383, never 384..511); 384 bytes total.
3. dump_ch=6 -> no ram_rd_en; single trmt with tx_data=8'hEE and nak=1; dump_done after tx_done. Repeat with dump_ch=2, trig_pos=400 -> same NAK behaviour.
4. Second dump_req with dump_ch=5 issued 10 cycles into a dump -> ignored; ram_sel stays at the original channel; exactly 384 bytes; single dump_done.
5. rst_n asserted after byte 100's trmt -> all outputs reset asynchronously; no dump_done. A new dump_req after release restarts at trig_pos with the counter at 0.
6. First-byte timing: dump_req at cycle N -> ram_rd_en at N+1, trmt at N+3. tx_done delay of 1 cycle vs 10000 cycles -> identical byte stream, with ram_rd_en 1 cycle after each tx_done.
